// File: rtl/multi_channel_frequency_counter.sv
// Gated multi-channel frequency counter: counts synchronized rising edges of each
// vol input over a gate window of len clk cycles and latches the results.
//
// state  | meaning
// S_IDLE | no window open; edges are ignored, results held
// S_GATE | window open; timer runs, live counters accumulate edges

module multi_channel_frequency_counter #(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 16,
    parameter int GATE_W   = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          vol,
    input  logic [GATE_W-1:0]            gate_len,
    input  logic                         start,
    input  logic                         continuous,
    input  logic                         clear,
    output logic [CHANNELS*COUNT_W-1:0]  count,
    output logic [CHANNELS-1:0]          overflow,
    output logic                         valid,
    output logic                         busy
);

    typedef enum logic {
        S_IDLE,
        S_GATE
    } state_t;

    localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_nx;
    logic                 win_open;
    logic                 win_end;

    logic [CHANNELS-1:0]  sync1;
    logic [CHANNELS-1:0]  sync2;
    logic [CHANNELS-1:0]  sync3;
    logic [CHANNELS-1:0]  edge_s;

    logic [GATE_W-1:0]    timer;
    logic [GATE_W-1:0]    len;
    logic [GATE_W-1:0]    len_eff;

    logic [COUNT_W-1:0]   live [CHANNELS];
    logic [COUNT_W-1:0]   sum  [CHANNELS];
    logic [CHANNELS-1:0]  live_ovf;
    logic [CHANNELS-1:0]  inc_sat;

    // Synchronizers run in every state so entering a window never sees a stale edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= vol;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_s  = sync2 & ~sync3;
    assign len_eff = (gate_len == '0) ? GATE_ONE : gate_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        win_open = 1'b0;
        win_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_GATE;
                    win_open = 1'b1;
                end
            end
            S_GATE: begin
                if (timer == len - GATE_ONE) begin
                    win_end = 1'b1;
                    if (continuous) begin
                        state_nx = S_GATE;
                        win_open = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort beats both a new start and a closing window.
        if (clear) begin
            state_nx = S_IDLE;
            win_open = 1'b0;
            win_end  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
            len   <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (win_open) begin
            timer <= '0;
            len   <= len_eff;
        end else if (state == S_GATE) begin
            timer <= timer + GATE_ONE;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            inc_sat[i] = edge_s[i] & (live[i] == '1);
            sum[i]     = (live[i] == '1) ? live[i]
                                         : live[i] + {{(COUNT_W-1){1'b0}}, edge_s[i]};
        end
    end

    // Live counters restart on the closing cycle itself, so back-to-back windows lose no edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                live[i] <= '0;
            end
            live_ovf <= '0;
        end else if (clear || win_open || win_end) begin
            for (int i = 0; i < CHANNELS; i++) begin
                live[i] <= '0;
            end
            live_ovf <= '0;
        end else if (state == S_GATE) begin
            for (int i = 0; i < CHANNELS; i++) begin
                live[i] <= sum[i];
            end
            live_ovf <= live_ovf | inc_sat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            overflow <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= win_end;
            if (win_end) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    count[i*COUNT_W +: COUNT_W] <= sum[i];
                end
                overflow <= live_ovf | inc_sat;
            end
        end
    end

    assign busy = (state == S_GATE);

endmodule

// File: tb/tb_multi_channel_frequency_counter.sv
// Directed bench for multi_channel_frequency_counter: a 16-bit and a 4-bit counter
// instance share stimulus; expected counts are worked out from the input periods.

module tb_multi_channel_frequency_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vol;
    logic [23:0] gate_len;
    logic        start;
    logic        continuous;
    logic        clear;

    logic [63:0] c16;
    logic [3:0]  ovf16;
    logic        valid16;
    logic        busy16;
    logic [15:0] c4;
    logic [3:0]  ovf4;
    logic        valid4;
    logic        busy4;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          per [4];
    logic [3:0]  man;
    int          n;
    int          acc;

    multi_channel_frequency_counter #(.CHANNELS(4), .COUNT_W(16), .GATE_W(24)) dut16 (
        .clk(clk), .reset(reset), .vol(vol), .gate_len(gate_len), .start(start),
        .continuous(continuous), .clear(clear), .count(c16), .overflow(ovf16),
        .valid(valid16), .busy(busy16)
    );

    multi_channel_frequency_counter #(.CHANNELS(4), .COUNT_W(4), .GATE_W(24)) dut4 (
        .clk(clk), .reset(reset), .vol(vol), .gate_len(gate_len), .start(start),
        .continuous(continuous), .clear(clear), .count(c4), .overflow(ovf4),
        .valid(valid4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get16(input int ch);
        return c16[ch*16 +: 16];
    endfunction

    function automatic logic [3:0] get4(input int ch);
        return c4[ch*4 +: 4];
    endfunction

    // One clock: sample point is 1 time unit after the rising edge, inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            vol[i] = man[i] | ((per[i] != 0) && ((cyc % per[i]) < (per[i] / 2)));
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic wait_valid(input int maxc, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!valid16 && cnt < maxc);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        vol        = '0;
        gate_len   = '0;
        start      = 1'b0;
        continuous = 1'b0;
        clear      = 1'b0;
        man        = '0;
        for (int i = 0; i < 4; i++) per[i] = 0;

        #3 reset = 1'b0;
        #2;
        check("rst_count", c16, 64'd0);
        check("rst_ovf", ovf16, 4'd0);
        check("rst_valid", valid16, 1'b0);
        check("rst_busy", busy16, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        // single shot, ch0 period 10, 100-cycle window
        per[0] = 10;
        idle(25);
        gate_len = 24'd100;
        pulse_start();
        check("t1_busy_rise", busy16, 1'b1);
        check("t1_valid_early", valid16, 1'b0);
        wait_valid(200, n);
        check("t1_latency", n + 1, 101);
        check("t1_cnt0", get16(0), 16'd10);
        check("t1_cnt0_w4", get4(0), 4'd10);
        check("t1_cnt1", get16(1), 16'd0);
        check("t1_cnt3", get16(3), 16'd0);
        check("t1_ovf", ovf16, 4'd0);
        check("t1_busy_fall", busy16, 1'b0);
        step();
        check("t1_valid_width", valid16, 1'b0);
        check("t1_cnt_hold", get16(0), 16'd10);

        // continuous, ch1 period 5, 50-cycle windows
        per[0] = 0;
        per[1] = 5;
        idle(20);
        gate_len   = 24'd50;
        continuous = 1'b1;
        pulse_start();
        acc = 0;
        for (int w = 0; w < 4; w++) begin
            wait_valid(100, n);
            check("t2_period", n, 50);
            check("t2_cnt1", get16(1), 16'd10);
            check("t2_cnt1_w4", get4(1), 4'd10);
            check("t2_cnt0", get16(0), 16'd0);
            acc += int'(get16(1));
            if (w < 3) check("t2_busy_hold", busy16, 1'b1);
            if (w == 2) continuous = 1'b0;
        end
        check("t2_busy_end", busy16, 1'b0);
        check("t2_sum", acc, 40);

        // saturation: 32 edges in 64 cycles, then 5 edges in 10 cycles
        per[1] = 0;
        per[2] = 2;
        idle(10);
        gate_len = 24'd64;
        pulse_start();
        wait_valid(100, n);
        check("t3_len", n, 64);
        check("t3_cnt2_w4", get4(2), 4'd15);
        check("t3_ovf_w4", ovf4, 4'b0100);
        check("t3_cnt2_w16", get16(2), 16'd32);
        check("t3_ovf_w16", ovf16, 4'd0);
        idle(3);
        gate_len = 24'd10;
        pulse_start();
        wait_valid(40, n);
        check("t3b_len", n, 10);
        check("t3b_cnt2_w4", get4(2), 4'd5);
        check("t3b_ovf_w4", ovf4, 4'd0);

        // clear mid-window, then start+clear collision
        gate_len = 24'd100;
        pulse_start();
        idle(29);
        check("t4_busy_pre", busy16, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t4_busy_clr", busy16, 1'b0);
        wait_valid(120, n);
        check("t4_no_valid", n, 120);
        check("t4_cnt_kept", get4(2), 4'd5);
        check("t4_cnt_kept16", get16(2), 16'd5);
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        check("t4_collide_busy", busy16, 1'b0);
        idle(5);
        check("t4_collide_idle", busy16, 1'b0);

        // asynchronous reset mid-window, then a gate_len=0 window
        per[2] = 0;
        idle(5);
        gate_len = 24'd100;
        pulse_start();
        idle(39);
        check("t5_busy_pre", busy16, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_rst_count", c16, 64'd0);
        check("t5_rst_busy", busy16, 1'b0);
        check("t5_rst_valid", valid16, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        check("t5_idle_after", busy16, 1'b0);
        gate_len = 24'd0;
        pulse_start();
        check("t5_len1_busy", busy16, 1'b1);
        check("t5_len1_v1", valid16, 1'b0);
        step();
        check("t5_len1_v2", valid16, 1'b1);
        check("t5_len1_busy_end", busy16, 1'b0);
        step();
        check("t5_len1_v3", valid16, 1'b0);

        // edge detected on the final cycle of a continuous window
        gate_len   = 24'd20;
        continuous = 1'b1;
        idle(3);
        pulse_start();
        idle(16);
        man[0] = 1'b1;
        step();
        man[0] = 1'b0;
        wait_valid(10, n);
        check("t6_w1_time", n, 3);
        check("t6_w1_cnt0", get16(0), 16'd1);
        idle(8);
        man[0] = 1'b1;
        step();
        man[0] = 1'b0;
        continuous = 1'b0;
        wait_valid(30, n);
        check("t6_w2_time", n, 11);
        check("t6_w2_cnt0", get16(0), 16'd1);
        check("t6_w2_cnt0_w4", get4(0), 4'd1);
        check("t6_busy_end", busy16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
